sine_taylor_shell: RTL and testbench

//  Pipelined fixed-point sine: y = sin(x) for unsigned Q4.8 x, signed Q4.12 y.

---
 rtl/sine_taylor_shell.sv | 114 +++++++++++
 tb/tb_sine_taylor_shell.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sine_taylor_shell.sv
// sine_taylor_shell: pipelined sin(x) for unsigned Q4.8 angles. The angle is folded
// into [-pi/2, pi/2] and a 4-term Taylor polynomial produces a signed Q4.12 result.
module sine_taylor_shell #(
  parameter int INT_BITS_I = 12,
  parameter int INT_BITS_O = 16
) (
  input  logic                         clk_sh_i,
  input  logic                         srst_sh_i,
  input  logic [INT_BITS_I-1:0]        x_sh_i,
  output logic signed [INT_BITS_O-1:0] sinx_sh_o
);

  // Angle constants in Q.16, rounded to nearest
  localparam logic signed [23:0] FOUR_PI = 24'sd823550;
  localparam logic signed [23:0] TWO_PI  = 24'sd411775;
  localparam logic signed [23:0] PI      = 24'sd205887;
  localparam logic signed [23:0] HALF_PI = 24'sd102944;

  // Taylor coefficients 1/6, 1/120, 1/5040 in Q0.16
  localparam logic signed [23:0] C3 = 24'sd10923;
  localparam logic signed [23:0] C5 = 24'sd546;
  localparam logic signed [23:0] C7 = 24'sd13;

  localparam logic signed [47:0] ROUND_HALF = 48'sd524288;
  localparam logic signed [47:0] SAT_POS    = 48'sd4096;
  localparam logic signed [47:0] SAT_NEG    = -48'sd4096;

  logic signed [23:0] x_q16;
  logic signed [23:0] wrapped;
  logic signed [23:0] centered;
  logic signed [23:0] folded;

  logic signed [17:0] r_s1;
  logic signed [17:0] r_s2;
  logic signed [19:0] r2_s2;
  logic signed [21:0] r3_s2;
  logic signed [17:0] r_s3;
  logic signed [21:0] r3_s3;
  logic signed [23:0] r5_s3;
  logic signed [23:0] r7_s3;

  logic signed [19:0] r2_c;
  logic signed [21:0] r3_c;
  logic signed [23:0] r5_c;
  logic signed [23:0] r7_c;
  logic signed [47:0] acc;
  logic signed [47:0] s_round;
  logic signed [15:0] s_sat;

  assign x_q16 = {{(24 - INT_BITS_I - 8){1'b0}}, x_sh_i, 8'h00};

  // Remove whole turns, recentre on zero, then mirror about +/-pi/2
  always_comb begin
    wrapped = x_q16;
    if (x_q16 >= FOUR_PI)
      wrapped = x_q16 - FOUR_PI;
    else if (x_q16 >= TWO_PI)
      wrapped = x_q16 - TWO_PI;

    centered = wrapped;
    if (wrapped >= PI)
      centered = wrapped - TWO_PI;

    folded = centered;
    if (centered > HALF_PI)
      folded = PI - centered;
    else if (centered < -HALF_PI)
      folded = -PI - centered;
  end

  assign r2_c = 20'((36'(r_s1) * 36'(r_s1)) >>> 16);
  assign r3_c = 22'((38'(r2_c) * 38'(r_s1)) >>> 16);
  assign r5_c = 24'((44'(r3_s2) * 44'(r2_s2)) >>> 16);
  assign r7_c = 24'((44'(r5_c) * 44'(r2_s2)) >>> 16);

  // Accumulate in Q.32 so only the final rounding loses precision
  always_comb begin
    acc = (48'(r_s3) <<< 16)
        - 48'(r3_s3) * 48'(C3)
        + 48'(r5_s3) * 48'(C5)
        - 48'(r7_s3) * 48'(C7);
    s_round = (acc + ROUND_HALF) >>> 20;
    s_sat = s_round[15:0];
    if (s_round > SAT_POS)
      s_sat = 16'sh1000;
    else if (s_round < SAT_NEG)
      s_sat = 16'shF000;
  end

  always_ff @(posedge clk_sh_i) begin
    if (!srst_sh_i) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r2_s2     <= '0;
      r3_s2     <= '0;
      r_s3      <= '0;
      r3_s3     <= '0;
      r5_s3     <= '0;
      r7_s3     <= '0;
      sinx_sh_o <= '0;
    end else begin
      r_s1      <= 18'(folded);
      r_s2      <= r_s1;
      r2_s2     <= r2_c;
      r3_s2     <= r3_c;
      r_s3      <= r_s2;
      r3_s3     <= r3_s2;
      r5_s3     <= r5_c;
      r7_s3     <= r7_c;
      sinx_sh_o <= INT_BITS_O'(s_sat);
    end
  end

endmodule

// File: tb/tb_sine_taylor_shell.sv
// tb_sine_taylor_shell: directed vectors, back-to-back streaming, mid-stream reset
// and a full-range sweep of sine_taylor_shell against real-valued sin().
module tb_sine_taylor_shell;

  logic               clk = 1'b0;
  logic               srst_n;
  logic [11:0]        x;
  logic signed [15:0] sinx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] x;
    int          lo;
    int          hi;
    string       name;
  } vec_t;

  vec_t vecs[12];

  // Expectations for the four inputs currently in flight; slot 3 is due next
  int    exp_lo[4];
  int    exp_hi[4];
  bit    exp_vld[4];
  string exp_name[4];

  always #5 clk = ~clk;

  sine_taylor_shell dut (
    .clk_sh_i  (clk),
    .srst_sh_i (srst_n),
    .x_sh_i    (x),
    .sinx_sh_o (sinx)
  );

  function automatic int sin_ref(input int xv);
    real v;
    v = $sin(real'(xv) / 256.0) * 4096.0;
    if (v >= 0.0)
      return $rtoi(v + 0.5);
    else
      return -$rtoi(-v + 0.5);
  endfunction

  task automatic checkOutput(input string name, input int lo, input int hi);
    checks++;
    if ($isunknown(sinx) || int'(sinx) < lo || int'(sinx) > hi) begin
      errors++;
      $display("[TB] FAIL %s: sinx=%0d (0x%04h) expected %0d..%0d", name, sinx, sinx, lo, hi);
    end
  endtask

  // One clock per call: check the oldest in-flight result, then drive the next input
  task automatic applyStimulus(input logic [11:0] xv, input logic rst_n,
                               input int lo, input int hi, input string name);
    @(negedge clk);
    if (exp_vld[3])
      checkOutput(exp_name[3], exp_lo[3], exp_hi[3]);
    for (int i = 3; i > 0; i--) begin
      exp_lo[i]   = exp_lo[i-1];
      exp_hi[i]   = exp_hi[i-1];
      exp_vld[i]  = exp_vld[i-1];
      exp_name[i] = exp_name[i-1];
    end
    exp_lo[0]   = lo;
    exp_hi[0]   = hi;
    exp_vld[0]  = 1'b1;
    exp_name[0] = name;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        exp_lo[i]   = 0;
        exp_hi[i]   = 0;
        exp_vld[i]  = 1'b1;
        exp_name[i] = "reset_flush";
      end
    end
    x      = xv;
    srst_n = rst_n;
  endtask

  initial begin
    int e;
    srst_n = 1'b0;
    x      = 12'h000;
    for (int i = 0; i < 4; i++) begin
      exp_vld[i] = 1'b0;
      exp_lo[i]  = 0;
      exp_hi[i]  = 0;
    end

    vecs[0]  = '{12'h180,  4084,  4088, "x_1p5"};
    vecs[1]  = '{12'h640,  -138,  -134, "x_6p25"};
    vecs[2]  = '{12'h280,  2449,  2453, "x_2p5"};
    vecs[3]  = '{12'h000,     0,     0, "x_zero"};
    vecs[4]  = '{12'h192,  4094,  4096, "x_half_pi"};
    vecs[5]  = '{12'hFFF, -1166, -1162, "x_max"};
    vecs[6]  = '{12'h324,     2,     6, "x_near_pi"};
    vecs[7]  = '{12'h4B6, -4096, -4094, "x_3half_pi"};
    vecs[8]  = '{12'h648,   -10,    -6, "x_near_2pi"};
    vecs[9]  = '{12'hC90,   -18,   -14, "x_below_4pi"};
    vecs[10] = '{12'hC91,    -2,     2, "x_above_4pi"};
    vecs[11] = '{12'h100,  3445,  3449, "x_1p0"};

    // Reset held two clocks with a live input, then the first real sample
    applyStimulus(12'h180, 1'b0, 0, 0, "reset_hold");
    applyStimulus(12'h180, 1'b0, 0, 0, "reset_hold");
    applyStimulus(12'h180, 1'b1, 4084, 4088, "first_after_reset");

    for (int i = 0; i < 12; i++)
      applyStimulus(vecs[i].x, 1'b1, vecs[i].lo, vecs[i].hi, vecs[i].name);

    applyStimulus(12'h180, 1'b1, 4084, 4088, "b2b_1p5");
    applyStimulus(12'h640, 1'b1, -138, -134, "b2b_6p25");
    applyStimulus(12'h280, 1'b1, 2449, 2453, "b2b_2p5");

    // Full sweep with a two-clock reset dropped into the middle of the stream
    for (int xi = 0; xi < 4096; xi++) begin
      e = sin_ref(xi);
      if (xi == 2048 || xi == 2049)
        applyStimulus(12'(xi), 1'b0, 0, 0, "sweep_reset");
      else
        applyStimulus(12'(xi), 1'b1, e - 2, e + 2, "sweep");
    end

    for (int i = 0; i < 4; i++)
      applyStimulus(12'h000, 1'b1, 0, 0, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
